// File: rtl/axi_arb_pkg.sv
// Shared widths, AXI write-channel payload structs and arbiter state encoding
// for the AXI write arbiter and its round-robin selector.
package axi_arb_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LENGTH     = 8;
  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [LENGTH-1:0]     awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
  } aw_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   wid;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
  } w_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
  } b_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin selector: first asserted request at or after rr_ptr, wrapping.
// Purely combinational so it can be shared with a future read-side arbiter.
module axi_rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan in priority order starting at rr_ptr; the first hit wins.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDX_W'((32'(rr_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: NREQ requesters share one AW/W/B path, with
// one transaction locked from AW grant through the B handshake.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic                Aclock,
  input  logic                Aresetn,
  input  aw_t  [NREQ-1:0]     req_aw,
  input  logic [NREQ-1:0]     req_awvalid,
  output logic [NREQ-1:0]     req_awready,
  input  w_t   [NREQ-1:0]     req_w,
  input  logic [NREQ-1:0]     req_wvalid,
  output logic [NREQ-1:0]     req_wready,
  output b_t   [NREQ-1:0]     req_b,
  output logic [NREQ-1:0]     req_bvalid,
  input  logic [NREQ-1:0]     req_bready,
  output aw_t                 m_aw,
  output logic                m_awvalid,
  input  logic                m_awready,
  output w_t                  m_w,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  b_t                  m_b,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                proto_err
);

  arb_state_e        state, state_d;
  logic [IDX_W-1:0]  gnt, gnt_d;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]  arb_idx;
  logic              any_req;
  logic [LENGTH-1:0] len_q, len_d;
  logic [LENGTH-1:0] beat_cnt, beat_d;
  logic              last_beat;
  logic [IDX_W-1:0]  gnt_next;

  axi_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_awvalid),
    .rr_ptr  (rr_ptr),
    .gnt_idx (arb_idx),
    .any_req (any_req)
  );

  assign last_beat = (beat_cnt == len_q);
  assign gnt_next  = (gnt == IDX_W'(NREQ - 1)) ? '0 : gnt + IDX_W'(1);

  // State and transaction context registers.
  always_ff @(posedge Aclock or negedge Aresetn) begin
    if (!Aresetn) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      rr_ptr   <= rr_ptr_d;
      len_q    <= len_d;
      beat_cnt <= beat_d;
    end
  end

  // Next state plus the zero-latency channel steering for the granted requester.
  always_comb begin
    state_d     = state;
    gnt_d       = gnt;
    rr_ptr_d    = rr_ptr;
    len_d       = len_q;
    beat_d      = beat_cnt;
    req_awready = '0;
    req_wready  = '0;
    req_bvalid  = '0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    proto_err   = 1'b0;
    m_aw        = req_aw[gnt];
    m_w         = req_w[gnt];
    m_w.wlast   = last_beat;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_b[i] = m_b;
    end

    unique case (state)
      IDLE: begin
        if (any_req) begin
          gnt_d   = arb_idx;
          len_d   = req_aw[arb_idx].awlen;
          beat_d  = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_awvalid        = 1'b1;
        req_awready[gnt] = m_awready;
        if (m_awready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_wvalid        = req_wvalid[gnt];
        req_wready[gnt] = m_wready;
        if (req_wvalid[gnt] && m_wready) begin
          // The arbiter's own beat count defines the burst end, not the requester.
          proto_err = (req_w[gnt].wlast != last_beat);
          if (last_beat) begin
            state_d = RESP;
          end else begin
            beat_d = beat_cnt + LENGTH'(1);
          end
        end
      end
      RESP: begin
        req_bvalid[gnt] = m_bvalid;
        m_bready        = req_bready[gnt];
        if (m_bvalid && req_bready[gnt]) begin
          state_d  = IDLE;
          rr_ptr_d = gnt_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized scoreboard bench for axi_wr_arbiter: a requester/slave driver, a
// queue-based round-robin reference model and a decoupled monitor.
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned IDX_W = 1;
  localparam int          MAXT  = 64;

  typedef struct {
    aw_t         aw;
    logic [31:0] dbase;
    logic [3:0]  strb;
    int          err_beat;
  } tx_t;

  typedef struct { int r; aw_t aw; }            exp_aw_t;
  typedef struct { int r; w_t w; logic perr; }  exp_w_t;
  typedef struct { int r; b_t b; }              exp_b_t;

  logic clk = 1'b0;
  logic rst_n;

  aw_t  [NREQ-1:0] req_aw;
  logic [NREQ-1:0] req_awvalid, req_awready;
  w_t   [NREQ-1:0] req_w;
  logic [NREQ-1:0] req_wvalid, req_wready;
  b_t   [NREQ-1:0] req_b;
  logic [NREQ-1:0] req_bvalid, req_bready;
  aw_t  m_aw;
  logic m_awvalid, m_awready;
  w_t   m_w;
  logic m_wvalid, m_wready;
  b_t   m_b;
  logic m_bvalid, m_bready;
  logic proto_err;

  axi_wr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .Aclock      (clk),
    .Aresetn     (rst_n),
    .req_aw      (req_aw),
    .req_awvalid (req_awvalid),
    .req_awready (req_awready),
    .req_w       (req_w),
    .req_wvalid  (req_wvalid),
    .req_wready  (req_wready),
    .req_b       (req_b),
    .req_bvalid  (req_bvalid),
    .req_bready  (req_bready),
    .m_aw        (m_aw),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_w         (m_w),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_b         (m_b),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  // Requester transaction lists and progress.
  tx_t  rtx [NREQ][MAXT];
  int   rcnt [NREQ];
  int   rhead [NREQ];
  logic awdone [NREQ];
  int   beat [NREQ];

  // Slave-side state.
  b_t   sl_q[$];
  logic sl_bpend;
  b_t   sl_bcur;

  // Scoreboard.
  exp_aw_t exp_aw[$];
  exp_w_t  exp_w[$];
  exp_b_t  exp_b[$];
  int      model_ptr;

  // Knobs.
  logic cfg_rand, cfg_wtoggle;
  int   bdelay_left;
  int   held_cnt;

  int n_chk, n_fail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  function automatic logic [NREQ-1:0] onehot(input int r);
    return NREQ'(1) << r;
  endfunction

  function automatic logic req_last(input tx_t t, input int b);
    if (t.err_beat >= 0) return (b == t.err_beat);
    return (b == int'(t.aw.awlen));
  endfunction

  task automatic add_txn(input int r, input logic [7:0] len, input logic [31:0] addr, input int eb);
    tx_t t;
    t.aw.awid    = 4'($urandom);
    t.aw.awaddr  = addr;
    t.aw.awlen   = len;
    t.aw.awsize  = 3'($urandom_range(0, 2));
    t.aw.awburst = 2'd1;
    t.dbase      = $urandom;
    t.strb       = 4'($urandom);
    t.err_beat   = eb;
    rtx[r][rcnt[r]] = t;
    rcnt[r]++;
  endtask

  // Reference: serve pending transactions one at a time in round-robin order.
  task automatic model_expect();
    int h [NREQ];
    int g;
    int r;
    tx_t t;
    for (int i = 0; i < NREQ; i++) h[i] = rhead[i];
    forever begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        r = (model_ptr + k) % NREQ;
        if (g < 0 && h[r] < rcnt[r]) g = r;
      end
      if (g < 0) break;
      t = rtx[g][h[g]];
      h[g]++;
      exp_aw.push_back('{r: g, aw: t.aw});
      for (int b = 0; b <= int'(t.aw.awlen); b++) begin
        exp_w.push_back('{r: g,
                          w: '{wid: t.aw.awid, wdata: t.dbase + 32'(b), wstrb: t.strb,
                               wlast: (b == int'(t.aw.awlen))},
                          perr: (req_last(t, b) != (b == int'(t.aw.awlen)))});
      end
      exp_b.push_back('{r: g, b: '{bid: t.aw.awid, bresp: t.aw.awaddr[1:0]}});
      model_ptr = (g + 1) % NREQ;
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int i;
    i = 0;
    while ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    if ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0) begin
      fail_now({nm, " timeout with transfers pending"});
      summary_and_finish();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_m_awvalid"},   64'(m_awvalid),   64'(0));
    chk({tag, "_m_wvalid"},    64'(m_wvalid),    64'(0));
    chk({tag, "_m_bready"},    64'(m_bready),    64'(0));
    chk({tag, "_req_awready"}, 64'(req_awready), 64'(0));
    chk({tag, "_req_wready"},  64'(req_wready),  64'(0));
    chk({tag, "_req_bvalid"},  64'(req_bvalid),  64'(0));
    chk({tag, "_proto_err"},   64'(proto_err),   64'(0));
  endtask

  task automatic clear_tb_state();
    for (int r = 0; r < NREQ; r++) begin
      rcnt[r] = 0; rhead[r] = 0; awdone[r] = 1'b0; beat[r] = 0;
    end
    exp_aw.delete(); exp_w.delete(); exp_b.delete(); sl_q.delete();
    sl_bpend = 1'b0;
    model_ptr = 0;
  endtask

  // Requester and slave driver: sample handshakes mid-cycle, update after the edge.
  initial begin : driver
    logic [NREQ-1:0] aw_hs, w_hs, b_hs;
    logic mw_last, mb_hs;
    logic has;
    tx_t  t;
    forever begin
      @(negedge clk);
      aw_hs   = req_awvalid & req_awready;
      w_hs    = req_wvalid & req_wready;
      b_hs    = req_bvalid & req_bready;
      mw_last = m_wvalid & m_wready & m_w.wlast;
      mb_hs   = m_bvalid & m_bready;
      if (m_awvalid && m_awready) sl_q.push_back('{bid: m_aw.awid, bresp: m_aw.awaddr[1:0]});
      if (bdelay_left > 0 && req_bvalid != '0) bdelay_left--;
      @(posedge clk);
      #1;
      if (mb_hs) sl_bpend = 1'b0;
      if (mw_last && sl_q.size() != 0) begin
        sl_bpend = 1'b1;
        sl_bcur  = sl_q.pop_front();
      end
      m_bvalid  = sl_bpend ? 1'b1 : (cfg_rand && $urandom_range(0, 3) == 0);
      m_b       = sl_bpend ? sl_bcur : '{bid: 4'hF, bresp: 2'b11};
      m_awready = cfg_rand ? 1'($urandom) : 1'b1;
      m_wready  = cfg_wtoggle ? ~m_wready : (cfg_rand ? 1'($urandom) : 1'b1);
      for (int r = 0; r < NREQ; r++) begin
        if (b_hs[r]) begin
          rhead[r]++; awdone[r] = 1'b0; beat[r] = 0;
        end else begin
          if (aw_hs[r]) awdone[r] = 1'b1;
          if (w_hs[r]) beat[r]++;
        end
        has = (rhead[r] < rcnt[r]);
        if (has) t = rtx[r][rhead[r]];
        req_awvalid[r] = has && !awdone[r];
        req_aw[r]      = has ? t.aw : '0;
        req_wvalid[r]  = has && (beat[r] <= int'(t.aw.awlen)) &&
                         (!cfg_rand || (req_wvalid[r] && !w_hs[r]) || $urandom_range(0, 3) != 0);
        req_w[r]       = has ? '{wid: t.aw.awid, wdata: t.dbase + 32'(beat[r]), wstrb: t.strb,
                                 wlast: req_last(t, beat[r])} : '0;
        req_bready[r]  = (bdelay_left > 0) ? 1'b0 : (cfg_rand ? 1'($urandom) : 1'b1);
      end
    end
  end

  // Monitor: compare every DUT handshake against the scoreboard heads.
  initial begin : monitor
    exp_aw_t ea;
    exp_w_t  ew;
    exp_b_t  eb;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_awvalid && m_awready) begin
          if (exp_aw.size() == 0) fail_now("aw_unexpected");
          else begin
            ea = exp_aw.pop_front();
            chk("aw_payload", 64'(m_aw), 64'(ea.aw));
            chk("aw_ready_route", 64'(req_awready), 64'(onehot(ea.r)));
          end
        end
        if (m_wvalid && m_wready) begin
          if (exp_w.size() == 0) fail_now("w_unexpected");
          else begin
            ew = exp_w.pop_front();
            chk("w_payload", 64'(m_w), 64'(ew.w));
            chk("w_ready_route", 64'(req_wready), 64'(onehot(ew.r)));
            chk("proto_err_beat", 64'(proto_err), 64'(ew.perr));
          end
        end else begin
          chk("proto_err_quiet", 64'(proto_err), 64'(0));
        end
        if (req_bvalid != '0) begin
          if (exp_b.size() == 0) fail_now("b_unexpected");
          else begin
            eb = exp_b[0];
            chk("b_route", 64'(req_bvalid), 64'(onehot(eb.r)));
            chk("b_payload", 64'(req_b[eb.r]), 64'(eb.b));
            if (req_bvalid[eb.r] && !req_bready[eb.r]) held_cnt++;
            if (req_bvalid[eb.r] && req_bready[eb.r]) void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  initial begin : main
    int i;
    n_chk = 0; n_fail = 0;
    cfg_rand = 1'b0; cfg_wtoggle = 1'b0; bdelay_left = 0; held_cnt = 0;
    req_aw = '0; req_awvalid = '0; req_w = '0; req_wvalid = '0; req_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_b = '0;
    clear_tb_state();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Single requester 0, four beats to 0x1000.
    add_txn(0, 8'd3, 32'h0000_1000, -1);
    model_expect(); wait_done("single_req0", 200);

    // Requester 1 alone brings the pointer back to 0.
    add_txn(1, 8'd1, 32'h0000_2000, -1);
    model_expect(); wait_done("single_req1", 200);

    // Both busy from pointer 0: three alternating rounds.
    for (int k = 0; k < 3; k++) begin
      add_txn(0, 8'($urandom_range(0, 3)), $urandom, -1);
      add_txn(1, 8'($urandom_range(0, 3)), $urandom, -1);
    end
    model_expect(); wait_done("alternate", 500);

    // One-beat burst with a toggling slave wready.
    cfg_wtoggle = 1'b1;
    add_txn(0, 8'd0, 32'h0000_3000, -1);
    model_expect(); wait_done("len0_toggle", 200);
    cfg_wtoggle = 1'b0;

    // Requester wlast on the second of four beats.
    add_txn(1, 8'd3, 32'h0000_4000, 1);
    model_expect(); wait_done("early_wlast", 200);

    // Slave error response held for five cycles with bready low.
    held_cnt = 0;
    bdelay_left = 5;
    add_txn(0, 8'd2, 32'h0000_2002, -1);
    model_expect(); wait_done("bresp_hold", 200);
    chk("bresp_hold_cycles", 64'(held_cnt), 64'(5));

    // Maximum burst length.
    add_txn(1, 8'd255, 32'h0000_5001, -1);
    model_expect(); wait_done("len255", 2000);

    // Randomized traffic with random handshake timing and spurious B.
    cfg_rand = 1'b1;
    for (int rnd = 0; rnd < 6; rnd++) begin
      for (int r = 0; r < NREQ; r++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          int len;
          int eb;
          len = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 5);
          eb  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
          add_txn(r, 8'(len), $urandom, eb);
        end
      end
      model_expect(); wait_done("random", 5000);
    end
    cfg_rand = 1'b0;
    repeat (3) @(negedge clk);

    // Abort mid-burst: pointer sits at 1 before the abort.
    add_txn(0, 8'd0, 32'h0000_6000, -1);
    model_expect(); wait_done("pre_abort", 200);
    add_txn(1, 8'd7, 32'h0000_7000, -1);
    model_expect();
    i = 0;
    while (beat[1] != 2 && i < 100) begin
      @(posedge clk);
      #3;
      i++;
    end
    if (beat[1] != 2) begin
      fail_now("abort_wait timeout");
      summary_and_finish();
    end
    rst_n = 1'b0;
    #1 check_quiet("abort");
    clear_tb_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    add_txn(1, 8'd1, 32'h0000_8000, -1);
    add_txn(0, 8'd1, 32'h0000_9000, -1);
    model_expect(); wait_done("post_reset", 300);

    repeat (3) @(negedge clk);
    summary_and_finish();
  end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Shares one downstream AXI write path (AW/W/B) between NREQ upstream write requesters. Round-robin arbitration; one write transaction in flight at a time, locked from AW grant through the B handshake. Sits between the master-side BFM/traffic sources and a single AXI slave on the `axi_if` bus, with the same 4-bit ID and 32-bit address/data widths and 8-bit length.

## Interface
- NREQ, 2, number of requesters (2..4)
- IDX_W, $clog2(NREQ), grant index width
- Aclock  input  1  bus clock; all state on rising edge
- Aresetn  input  1  asynchronous active-low reset
- req_aw  input  [NREQ] aw_t  per-requester AW payload (awid, awaddr, awlen, awsize, awburst)
- req_awvalid  input  NREQ  per-requester AW valid
- req_awready  output  NREQ  per-requester AW ready
- req_w  input  [NREQ] w_t  per-requester W payload (wid, wdata, wstrb, wlast)
- req_wvalid  input  NREQ  W valid
- req_wready  output  NREQ  W ready
- req_b  output  [NREQ] b_t  B payload (bid, bresp), fanned out to all requesters
- req_bvalid  output  NREQ  B valid, granted requester only
- req_bready  input  NREQ  B ready
- m_aw  output  aw_t  downstream AW payload
- m_awvalid  output  1  downstream AW valid
- m_awready  input  1  downstream AW ready
- m_w  output  w_t  downstream W payload
- m_wvalid  output  1  downstream W valid
- m_wready  input  1  downstream W ready
- m_b  input  b_t  downstream B payload
- m_bvalid  input  1  downstream B valid
- m_bready  output  1  downstream B ready
- proto_err  output  1  one-cycle pulse: requester wlast disagreed with beat count

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any req_awvalid, pick the first set bit at or after rr_ptr (wrapping). Register gnt, latch awlen into len_q, clear beat_cnt, go to ADDR. Otherwise stay.
- ADDR: m_aw = req_aw[gnt], m_awvalid = 1, req_awready[gnt] = m_awready. Go to DATA on m_awvalid && m_awready.
- DATA: m_w = req_w[gnt], except m_w.wlast is driven as (beat_cnt == len_q). m_wvalid = req_wvalid[gnt], req_wready[gnt] = m_wready. On each handshake, beat_cnt++. On the handshake with beat_cnt == len_q, go to RESP.
- RESP: req_bvalid[gnt] = m_bvalid, m_bready = req_bready[gnt]. On that handshake go to IDLE and set rr_ptr = gnt+1 mod NREQ.
- Non-granted requesters always see ready/valid = 0. All m_* valids and m_bready are 0 outside their owning state.
- proto_err: pulses on any DATA handshake where req_w[gnt].wlast != (beat_cnt == len_q). The transfer continues using the computed last.
- W before AW: data is held off (req_wready = 0) until the grant reaches DATA. No early write data.
- m_bvalid outside RESP: ignored (m_bready = 0).
- awlen = 0: one beat. awlen = 255: 256 beats. beat_cnt is 8 bits and is compared, never overflows past len_q.

## Timing
- Reset values: state IDLE, rr_ptr 0, gnt 0, len_q 0, beat_cnt 0. Every valid/ready output and proto_err = 0. Payload outputs are don't-care (mux of gnt 0).
- Reset asserted mid-transaction aborts it immediately; outputs drop asynchronously.
- Grant latency: req_awvalid sampled high in IDLE at edge N gives m_awvalid high after edge N. Minimum 1 idle cycle between transactions (RESP→IDLE→ADDR).
- W and B paths are combinational pass-through in their states (zero added latency). The AW payload is muxed combinationally from the registered gnt.
- Requesters hold AW payload stable while awvalid is high (AXI rule). The arbiter does not register it.
- Simultaneous requests in IDLE: round-robin order from rr_ptr. A requester dropping awvalid before grant is simply not selected.

## Structure
- Package axi_arb_pkg: ADDR_WIDTH = 32, DATA_WIDTH = 32, LENGTH = 8, ID_WIDTH = 4; packed structs aw_t, w_t, b_t; state enum arb_state_e.
- Sub-module axi_rr_arbiter (req vector, rr_ptr → grant index + any_req), reused for a future read arbiter.

## Test plan
- Single requester 0, awlen = 3, awaddr = 0x1000, slave always ready → 4 beats on m_w, m_w.wlast only on beat 4, B forwarded to req 0 only, rr_ptr = 1.
- Req 0 and 1 both assert awvalid in IDLE with rr_ptr = 0 → req 0 served first, then req 1. Three back-to-back rounds alternate 0,1,0,1,0,1.
- awlen = 0 with slave wready toggling 1-0-1 → exactly 1 beat transferred, wlast = 1, then RESP.
- Requester asserts wlast on beat 2 of awlen = 3 → proto_err pulses one cycle on that beat; transfer completes 4 beats.
- Slave holds m_bvalid with bresp = 2'b10 while req_bready = 0 for 5 cycles → FSM stays RESP, req_bvalid[gnt] = 1, bresp passed through; completes when bready rises.
- Aresetn dropped mid-DATA (beat 2 of 8) → all valids/readies 0 immediately. After release: IDLE, rr_ptr = 0, and a new request is granted normally.
